// File: rtl/adder_tree_arb_pkg.sv
// Shared types and latency helpers for the adder-tree request scheduler.
package adder_tree_arb_pkg;

    // Tag ID field is sized for the largest supported requester count.
    localparam int unsigned TAG_ID_W = 8;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int unsigned calc_lat(input int unsigned elems);
        return $clog2(elems) + 1;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned elems);
        return $clog2(calc_lat(elems) + 2);
    endfunction

endpackage

// File: rtl/naive_adder_tree.sv
// Pipelined floating-point reduction tree; exponent widens one bit per level, truncating adds.
module naive_adder_tree #(
    parameter  int unsigned EXP_WIDTH_I  = 8,
    parameter  int unsigned MANT_WIDTH_I = 23,
    parameter  int unsigned ELEMS_COUNT  = 32,
    localparam int unsigned BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int unsigned TREE_DEPTH   = $clog2(ELEMS_COUNT),
    localparam int unsigned SUM_WIDTH_O  = BIT_WIDTH_I + TREE_DEPTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] i_vec,
    output logic [SUM_WIDTH_O-1:0]                  o_sum
);

    localparam int unsigned EW    = EXP_WIDTH_I + TREE_DEPTH;
    localparam int unsigned MW    = MANT_WIDTH_I;
    localparam int unsigned NODES = 2 * ELEMS_COUNT;

    // Heap layout: node 1 is the root, leaves occupy ELEMS_COUNT..NODES-1.
    logic [SUM_WIDTH_O-1:0] node_d [1:NODES-1];
    logic [SUM_WIDTH_O-1:0] node_q [1:NODES-1];

    function automatic logic [SUM_WIDTH_O-1:0] fp_add(input logic [SUM_WIDTH_O-1:0] a,
                                                      input logic [SUM_WIDTH_O-1:0] b);
        logic [SUM_WIDTH_O-1:0] big, sml;
        logic [EW-1:0]          e_big, e_sml, e_res, d;
        logic [MW+1:0]          m_big, m_sml, m_res;
        int unsigned            lead;
        big = a;
        sml = b;
        if (b[EW+MW-1:0] > a[EW+MW-1:0]) begin
            big = b;
            sml = a;
        end
        e_big = big[MW +: EW];
        e_sml = sml[MW +: EW];
        // A zero exponent encodes zero; denormals are flushed.
        if (e_sml == '0) return big;
        d     = e_big - e_sml;
        m_big = {1'b0, 1'b1, big[MW-1:0]};
        m_sml = (d > EW'(MW + 1)) ? '0 : ({1'b0, 1'b1, sml[MW-1:0]} >> d);
        e_res = e_big;
        if (big[SUM_WIDTH_O-1] == sml[SUM_WIDTH_O-1]) begin
            m_res = m_big + m_sml;
            if (m_res[MW+1]) begin
                e_res = e_big + EW'(1);
                m_res = m_res >> 1;
            end
        end else begin
            m_res = m_big - m_sml;
            if (m_res == '0) return '0;
            lead = 0;
            for (int i = 0; i <= int'(MW); i++) begin
                if (m_res[i]) lead = i;
            end
            if (e_big <= EW'(MW - lead)) return '0;
            e_res = e_big - EW'(MW - lead);
            m_res = m_res << (MW - lead);
        end
        return {big[SUM_WIDTH_O-1], e_res, m_res[MW-1:0]};
    endfunction

    always_comb begin
        for (int i = 1; i < int'(ELEMS_COUNT); i++) begin
            node_d[i] = fp_add(node_q[2*i], node_q[2*i+1]);
        end
        for (int j = 0; j < int'(ELEMS_COUNT); j++) begin
            node_d[int'(ELEMS_COUNT)+j] = {i_vec[j][BIT_WIDTH_I-1], {TREE_DEPTH{1'b0}},
                                           i_vec[j][BIT_WIDTH_I-2:0]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < int'(NODES); i++) node_q[i] <= '0;
        end else begin
            node_q <= node_d;
        end
    end

    assign o_sum = node_q[1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched cyclically from a rotating pointer.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned REQ_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [REQ_W-1:0]   idx_o
);

    logic [REQ_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int c;
        c     = 0;
        gnt_o = '0;
        idx_o = '0;
        // Walk from farthest to nearest so the nearest valid request wins.
        for (int o = int'(NUM_REQ) - 1; o >= 0; o--) begin
            c = int'(ptr_q) + o;
            if (c >= int'(NUM_REQ)) c = c - int'(NUM_REQ);
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = REQ_W'(c);
            end
        end
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (int'(idx_o) == int'(NUM_REQ) - 1) ? '0 : idx_o + REQ_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one reduction tree among NUM_REQ requesters; a tag pipe returns each sum with its ID.
module adder_tree_arbiter
    import adder_tree_arb_pkg::*;
#(
    parameter  int unsigned EXP_WIDTH_I  = 8,
    parameter  int unsigned MANT_WIDTH_I = 23,
    parameter  int unsigned ELEMS_COUNT  = 32,
    parameter  int unsigned NUM_REQ      = 4,
    localparam int unsigned BIT_WIDTH_I  = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int unsigned TREE_DEPTH   = $clog2(ELEMS_COUNT),
    localparam int unsigned SUM_WIDTH_O  = BIT_WIDTH_I + TREE_DEPTH,
    localparam int unsigned REQ_W        = $clog2(NUM_REQ),
    localparam int unsigned LAT          = calc_lat(ELEMS_COUNT),
    localparam int unsigned CNT_W        = calc_cnt_w(ELEMS_COUNT)
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 en_i,
    input  logic [NUM_REQ-1:0]                                   req_valid_i,
    input  logic [NUM_REQ-1:0][ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] req_vec_i,
    output logic [NUM_REQ-1:0]                                   req_ready_o,
    output logic                                                 rsp_valid_o,
    output logic [REQ_W-1:0]                                     rsp_id_o,
    output logic [SUM_WIDTH_O-1:0]                               rsp_sum_o,
    output logic [CNT_W-1:0]                                     inflight_o,
    output logic                                                 busy_o
);

    logic [NUM_REQ-1:0]                    gnt;
    logic [REQ_W-1:0]                      gnt_idx;
    logic                                  transfer;
    logic [ELEMS_COUNT-1:0][BIT_WIDTH_I-1:0] tree_vec;
    logic [SUM_WIDTH_O-1:0]                tree_sum;

    tag_t                   tag_d [LAT];
    tag_t                   tag_q [LAT];
    logic                   rsp_valid_d, rsp_valid_q;
    logic [REQ_W-1:0]       rsp_id_d, rsp_id_q;
    logic [SUM_WIDTH_O-1:0] rsp_sum_d, rsp_sum_q;
    logic [CNT_W-1:0]       inflight_d, inflight_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid_i),
        .accept_i (transfer),
        .gnt_o    (gnt),
        .idx_o    (gnt_idx)
    );

    // Ready is suppressed while reset holds so nothing is accepted into a clearing pipe.
    assign req_ready_o = (en_i && rst_ni) ? gnt : '0;
    assign transfer    = |req_ready_o;
    assign tree_vec    = transfer ? req_vec_i[gnt_idx] : '0;

    naive_adder_tree #(
        .EXP_WIDTH_I  (EXP_WIDTH_I),
        .MANT_WIDTH_I (MANT_WIDTH_I),
        .ELEMS_COUNT  (ELEMS_COUNT)
    ) u_tree (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_vec  (tree_vec),
        .o_sum  (tree_sum)
    );

    always_comb begin
        tag_d[0].v  = transfer;
        tag_d[0].id = TAG_ID_W'(gnt_idx);
        for (int s = 1; s < int'(LAT); s++) tag_d[s] = tag_q[s-1];
        rsp_valid_d = tag_q[LAT-1].v;
        rsp_id_d    = tag_q[LAT-1].id[REQ_W-1:0];
        rsp_sum_d   = tag_q[LAT-1].v ? tree_sum : rsp_sum_q;
        inflight_d  = inflight_q;
        if (transfer && !rsp_valid_q) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!transfer && rsp_valid_q) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(LAT); s++) tag_q[s] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            inflight_q  <= '0;
        end else begin
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            inflight_q  <= inflight_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign inflight_o  = inflight_q;
    assign busy_o      = (inflight_q != '0);

endmodule
